// File: rtl/rf_pkg.sv
// Shared definitions for the multi-read-port register file: defaults, state encoding, clog2.
package rf_pkg;

  localparam int unsigned RF_WIDTH = 16;
  localparam int unsigned RF_DEPTH = 8;
  localparam int unsigned RF_NRP   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

  // Address width for a given entry count, never below 1 bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sweep sequencer: walks entry 0..DEPTH-1 one per cycle, raising busy for the sweep.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = RF_DEPTH,
  parameter int unsigned AW    = clog2(RF_DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rf_state_e     state;
  rf_state_e     state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter stops at DEPTH-1 and the sweep ends on that same edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = cnt;
    if (state == ST_CLEAR) begin
      busy   = 1'b1;
      clr_we = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_mrp.sv
// Parametrised register file with NRP combinational read ports, addressed write, parallel load
// and a hardware clear sweep. Define RF_MRP_WRITE_BYPASS_EN to forward idle writes to reads.
module reg_file_mrp
  import rf_pkg::*;
#(
  parameter  int unsigned WIDTH = RF_WIDTH,
  parameter  int unsigned DEPTH = RF_DEPTH,
  parameter  int unsigned NRP   = RF_NRP,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   load_en,
  input  logic [DEPTH*WIDTH-1:0] load_data,
  input  logic [NRP*AW-1:0]      rd_addr,
  output logic [NRP*WIDTH-1:0]   rd_data,
  input  logic                   clr_req,
  output logic                   busy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr_addr_ok;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clock    (clock),
    .reset    (reset),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_addr_ok = (32'(wr_addr) < DEPTH);

  // Priority: sweep, then a clear request (drops everything), then load, then single write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (!clr_req) begin
      if (load_en) begin
        for (int i = 0; i < int'(DEPTH); i++)
          mem[i] <= load_data[WIDTH*(int'(DEPTH)-1-i) +: WIDTH];
      end else if (wr_en && wr_addr_ok) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

`ifdef RF_MRP_WRITE_BYPASS_EN
  logic bypass_ok;
  assign bypass_ok = wr_en && wr_addr_ok && !busy && !clr_req && !load_en && !reset;
`endif

  for (genvar p = 0; p < int'(NRP); p++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rv;

    assign ra = rd_addr[AW*p +: AW];

    always_comb begin
      rv = '0;
      if (32'(ra) < DEPTH) rv = mem[ra];
`ifdef RF_MRP_WRITE_BYPASS_EN
      if (bypass_ok && (ra == wr_addr)) rv = wr_data;
`endif
    end

    assign rd_data[WIDTH*p +: WIDTH] = rv;
  end

endmodule

// File: tb/tb_reg_file_mrp.sv
// Bench for reg_file_mrp: array/queue reference model checked every cycle plus directed literals.
module tb_reg_file_mrp;

  localparam int W = 16;
  localparam int D = 8;
  localparam int N = 2;
  localparam int A = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           wr_en = 1'b0;
  logic [A-1:0]   wr_addr = '0;
  logic [W-1:0]   wr_data = '0;
  logic           load_en = 1'b0;
  logic [D*W-1:0] load_data = '0;
  logic [N*A-1:0] rd_addr = '0;
  logic [N*W-1:0] rd_data;
  logic           clr_req = 1'b0;
  logic           busy;

  int checks = 0;
  int errors = 0;

  reg_file_mrp dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .load_en   (load_en),
    .load_data (load_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .clr_req   (clr_req),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries as an array, pending clear sweep as a queue of addresses.
  logic [W-1:0] model [D];
  int           sweep_q [$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < D; i++) model[i] = '0;
      sweep_q.delete();
    end else if (sweep_q.size() != 0) begin
      model[sweep_q.pop_front()] = '0;
    end else if (clr_req) begin
      for (int i = 0; i < D; i++) sweep_q.push_back(i);
    end else if (load_en) begin
      for (int i = 0; i < D; i++) model[i] = load_data[W*(D-1-i) +: W];
    end else if (wr_en && int'(wr_addr) < D) begin
      model[wr_addr] = wr_data;
    end
  end

  function automatic logic [W-1:0] model_read(input int a);
    logic [W-1:0] v;
    v = (a < D) ? model[a] : '0;
`ifdef RF_MRP_WRITE_BYPASS_EN
    if (wr_en && !reset && sweep_q.size() == 0 && !clr_req && !load_en &&
        int'(wr_addr) < D && a == int'(wr_addr))
      v = wr_data;
`endif
    return v;
  endfunction

  always @(negedge clock) begin
    chk("model_busy", 32'(busy), 32'(sweep_q.size() != 0));
    for (int p = 0; p < N; p++)
      chk($sformatf("model_rd%0d", p), 32'(rd_data[W*p +: W]),
          32'(model_read(int'(rd_addr[A*p +: A]))));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {A'(a1), A'(a0)};
  endtask

  function automatic logic [W-1:0] port(input int p);
    return rd_data[W*p +: W];
  endfunction

  task automatic fill(input logic [W-1:0] v);
    for (int i = 0; i < D; i++) load_data[W*(D-1-i) +: W] = v;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h1357; tick();
    wr_addr = 3'd6; wr_data = 16'h2468; tick();
    wr_en = 1'b0;

    // Reset with arbitrary prior contents
    reset = 1'b1; #1;
    chk("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < D; i++) begin
      set_rd(i, i); #1;
      chk("rst_p0", 32'(port(0)), 32'h0);
      chk("rst_p1", 32'(port(1)), 32'h0);
    end
    tick();
    reset = 1'b0;
    tick();

    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hA5A5; tick();
    wr_addr = 3'd7; wr_data = 16'h1234; tick();
    wr_en = 1'b0;
    set_rd(3, 7); #1;
    chk("wr_p0_a3", 32'(port(0)), 32'hA5A5);
    chk("wr_p1_a7", 32'(port(1)), 32'h1234);
    set_rd(3, 3); #1;
    chk("same_p0", 32'(port(0)), 32'hA5A5);
    chk("same_p1", 32'(port(1)), 32'hA5A5);
    tick();

    // Load wins over concurrent write
    for (int i = 0; i < D; i++) load_data[W*(D-1-i) +: W] = W'(i);
    load_en = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hFFFF;
    tick();
    load_en = 1'b0; wr_en = 1'b0;
    set_rd(2, 7); #1;
    chk("load_a2", 32'(port(0)), 32'h0002);
    chk("load_a7", 32'(port(1)), 32'h0007);
    set_rd(0, 5); #1;
    chk("load_a0", 32'(port(0)), 32'h0000);
    chk("load_a5", 32'(port(1)), 32'h0005);

    // Full clear sweep with writes attempted during it
    fill(16'hFFFF);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    set_rd(0, 1); #1;
    chk("sweep_busy0", 32'(busy), 32'd1);
    chk("sweep_e0_pre", 32'(port(0)), 32'hFFFF);
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h1111;
    for (int k = 1; k <= D; k++) begin
      set_rd(k - 1, (k < D) ? k : 0);
      tick();
      if (k == D) wr_en = 1'b0;
      #1;
      chk($sformatf("sweep_busy%0d", k), 32'(busy), 32'(k < D));
      chk($sformatf("sweep_clr%0d", k), 32'(port(0)), 32'h0);
      if (k < D) chk($sformatf("sweep_keep%0d", k), 32'(port(1)), 32'hFFFF);
    end
    for (int i = 0; i < D; i++) begin
      set_rd(i, i); #1;
      chk("sweep_all0", 32'(port(0)), 32'h0);
    end
    tick();

    // Reset in the middle of a sweep
    fill(16'hFFFF);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    tick(); tick(); tick(); tick();
    set_rd(3, 4); #1;
    chk("mid_e3", 32'(port(0)), 32'h0);
    chk("mid_e4", 32'(port(1)), 32'hFFFF);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1; #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    set_rd(5, 7); #1;
    chk("mid_rst_e5", 32'(port(0)), 32'h0);
    chk("mid_rst_e7", 32'(port(1)), 32'h0);
    tick();
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444; tick();
    wr_en = 1'b0;
    set_rd(4, 5); #1;
    chk("post_rst_wr", 32'(port(0)), 32'h4444);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Same-cycle write/read of one address
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
    set_rd(5, 4); #1;
`ifdef RF_MRP_WRITE_BYPASS_EN
    chk("bypass_same", 32'(port(0)), 32'hBEEF);
`else
    chk("bypass_same", 32'(port(0)), 32'h0000);
`endif
    chk("bypass_other", 32'(port(1)), 32'h4444);
    tick();
    wr_en = 1'b0; #1;
    chk("bypass_after", 32'(port(0)), 32'hBEEF);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
